cpu_controller: RTL and testbench

CPU_CONTROLLER -- requirements
Module: cpu_controller

---
 rtl/cpu_pkg.sv | 111 +++++++++++
 rtl/cpu_controller_instr_class.sv | 43 ++++
 rtl/cpu_controller.sv | 105 ++++++++++
 tb/tb_cpu_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU control FSM: states, instruction
// classes, opcode/op constants, select encodings and the per-state output table.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
    S_WIMM, S_GETA, S_GETB, S_ALU, S_WRC,
    S_ADDR, S_LADDR, S_MRD1, S_MRD2, S_GETD, S_STB, S_MWR,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam int ICLASS_W = 9;

  // Exactly one field is set for any {opcode, op}.
  typedef struct packed {
    logic mov_imm;
    logic mov_reg;
    logic alu;
    logic cmp;
    logic mvn;
    logic ldr;
    logic str;
    logic halt;
    logic nop;
  } iclass_t;

  typedef struct packed {
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] alu_op;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(state_t s, iclass_t c, logic [1:0] op);
    ctrl_t o;
    o = '0;
    case (s)
      S_RST:   begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
      S_IF1:   begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; end
      S_IF2:   begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; o.load_ir = 1'b1; end
      S_UPC:   o.load_pc = 1'b1;
      S_WIMM:  begin o.nsel = NSEL_RN; o.vsel = VSEL_IMM; o.write = 1'b1; end
      S_GETA:  begin o.nsel = NSEL_RN; o.loada = 1'b1; end
      S_GETB:  begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
      S_ALU: begin
        // MOV reg is an ADD of 0 + Rm; MVN negates Rm with A forced to 0.
        o.alu_op = c.mov_reg ? OP_ADD : op;
        o.asel   = c.mov_reg | c.mvn;
        if (c.cmp) o.loads = 1'b1;
        else       o.loadc = 1'b1;
      end
      S_WRC:   begin o.nsel = NSEL_RD; o.vsel = VSEL_C; o.write = 1'b1; end
      S_ADDR:  begin o.alu_op = OP_ADD; o.bsel = 1'b1; o.loadc = 1'b1; end
      S_LADDR: o.load_addr = 1'b1;
      S_MRD1:  o.mem_cmd = MEM_READ;
      S_MRD2: begin
        o.mem_cmd = MEM_READ;
        o.nsel    = NSEL_RD;
        o.vsel    = VSEL_MDATA;
        o.write   = 1'b1;
      end
      S_GETD:  begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
      S_STB:   begin o.asel = 1'b1; o.alu_op = OP_ADD; o.loadc = 1'b1; end
      S_MWR:   o.mem_cmd = MEM_WRITE;
      S_HALT:  o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cpu_controller_instr_class.sv
// Maps the decoder's {opcode, op} to a one-hot instruction class.
module instr_class
  import cpu_pkg::*;
(
  input  logic [2:0]          opcode,
  input  logic [1:0]          op,
  output logic [ICLASS_W-1:0] cls
);

  iclass_t c;

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    c = '0;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      c.mov_imm = 1'b1;
        else if (op == OP_MOV_REG) c.mov_reg = 1'b1;
        else                       c.nop     = 1'b1;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD, OP_AND: c.alu = 1'b1;
          OP_CMP:         c.cmp = 1'b1;
          default:        c.mvn = 1'b1;
        endcase
      end
      OPC_LDR: begin
        if (op == OP_MEM) c.ldr = 1'b1;
        else              c.nop = 1'b1;
      end
      OPC_STR: begin
        if (op == OP_MEM) c.str = 1'b1;
        else              c.nop = 1'b1;
      end
      OPC_HALT: c.halt = 1'b1;
      default:  c.nop  = 1'b1;
    endcase
  end

  assign cls = c;

endmodule

// File: rtl/cpu_controller.sv
// Moore control FSM for the simple CPU: fetch, decode, datapath and memory
// sequencing, with all control outputs registered alongside the state.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] alu_op,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  logic [ICLASS_W-1:0] cls_bits;
  iclass_t             cls;
  state_t              state, next_state;
  ctrl_t               ctrl_q;

  instr_class u_instr_class (
    .opcode (opcode),
    .op     (op),
    .cls    (cls_bits)
  );

  assign cls = iclass_t'(cls_bits);

  always_comb begin
    next_state = state;
    case (state)
      S_RST: next_state = S_IF1;
      S_IF1: next_state = S_IF2;
      S_IF2: next_state = S_UPC;
      S_UPC: next_state = S_DEC;
      S_DEC: begin
        if (cls.mov_imm)                         next_state = S_WIMM;
        else if (cls.mov_reg || cls.mvn)         next_state = S_GETB;
        else if (cls.alu || cls.cmp || cls.ldr || cls.str) next_state = S_GETA;
        else if (cls.halt)                       next_state = S_HALT;
        else                                     next_state = S_IF1;
      end
      S_WIMM:  next_state = S_IF1;
      S_GETA:  next_state = (cls.ldr || cls.str) ? S_ADDR : S_GETB;
      S_GETB:  next_state = S_ALU;
      S_ALU:   next_state = cls.cmp ? S_IF1 : S_WRC;
      S_WRC:   next_state = S_IF1;
      S_ADDR:  next_state = S_LADDR;
      S_LADDR: next_state = cls.ldr ? S_MRD1 : S_GETD;
      S_MRD1:  next_state = S_MRD2;
      S_MRD2:  next_state = S_IF1;
      S_GETD:  next_state = S_STB;
      S_STB:   next_state = S_MWR;
      S_MWR:   next_state = S_IF1;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  // Outputs are computed for the state being entered, so they change on the
  // same edge as the state and reset clears them together with it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= S_RST;
      ctrl_q <= ctrl_for(S_RST, '0, 2'b00);
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_for(next_state, cls, op);
    end
  end

  assign nsel      = ctrl_q.nsel;
  assign vsel      = ctrl_q.vsel;
  assign write     = ctrl_q.write;
  assign loada     = ctrl_q.loada;
  assign loadb     = ctrl_q.loadb;
  assign loadc     = ctrl_q.loadc;
  assign loads     = ctrl_q.loads;
  assign asel      = ctrl_q.asel;
  assign bsel      = ctrl_q.bsel;
  assign alu_op    = ctrl_q.alu_op;
  assign load_ir   = ctrl_q.load_ir;
  assign load_pc   = ctrl_q.load_pc;
  assign reset_pc  = ctrl_q.reset_pc;
  assign load_addr = ctrl_q.load_addr;
  assign addr_sel  = ctrl_q.addr_sel;
  assign mem_cmd   = ctrl_q.mem_cmd;
  assign halted    = ctrl_q.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: expected per-cycle output vectors are
// queued per instruction and compared one per clock at the falling edge.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [1:0] nsel, vsel, alu_op, mem_cmd;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic       load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;

  int checks   = 0;
  int failures = 0;

  typedef enum int {
    B_RST, B_IF1, B_IF2, B_UPC, B_DEC, B_WIMM, B_GETA, B_GETB, B_ALU, B_WRC,
    B_ADDR, B_LADDR, B_MRD1, B_MRD2, B_GETD, B_STB, B_MWR, B_HALT
  } bst_t;

  // ALU flavours for the ALU state expectation.
  localparam int K_ADD = 0, K_CMP = 1, K_AND = 2, K_MOVR = 3, K_MVN = 4;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .op        (op),
    .nsel      (nsel),
    .vsel      (vsel),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .asel      (asel),
    .bsel      (bsel),
    .alu_op    (alu_op),
    .load_ir   (load_ir),
    .load_pc   (load_pc),
    .reset_pc  (reset_pc),
    .load_addr (load_addr),
    .addr_sel  (addr_sel),
    .mem_cmd   (mem_cmd),
    .halted    (halted)
  );

  wire [20:0] obs_v = {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
                       alu_op, load_ir, load_pc, reset_pc, load_addr, addr_sel,
                       mem_cmd, halted};

  function automatic logic [20:0] pk(
    input logic [1:0] n, input logic [1:0] v, input logic wr,
    input logic la, input logic lb, input logic lc, input logic ls,
    input logic as, input logic bs, input logic [1:0] alu,
    input logic ir, input logic lpc, input logic rpc, input logic lad,
    input logic ads, input logic [1:0] mem, input logic h);
    return {n, v, wr, la, lb, lc, ls, as, bs, alu, ir, lpc, rpc, lad, ads, mem, h};
  endfunction

  // Output table written directly from the state/action list.
  function automatic logic [20:0] expv(input bst_t s, input int k);
    case (s)
      B_RST:   return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,1,1,0,0, 2'b00,0);
      B_IF1:   return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,0,0,0,1, 2'b01,0);
      B_IF2:   return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 1,0,0,0,1, 2'b01,0);
      B_UPC:   return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,1,0,0,0, 2'b00,0);
      B_DEC:   return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,0);
      B_WIMM:  return pk(2'b00,2'b10,1, 0,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,0);
      B_GETA:  return pk(2'b00,2'b00,0, 1,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,0);
      B_GETB:  return pk(2'b10,2'b00,0, 0,1,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,0);
      B_ALU: begin
        case (k)
          K_CMP:  return pk(2'b00,2'b00,0, 0,0,0,1, 0,0,2'b01, 0,0,0,0,0, 2'b00,0);
          K_AND:  return pk(2'b00,2'b00,0, 0,0,1,0, 0,0,2'b10, 0,0,0,0,0, 2'b00,0);
          K_MOVR: return pk(2'b00,2'b00,0, 0,0,1,0, 1,0,2'b00, 0,0,0,0,0, 2'b00,0);
          K_MVN:  return pk(2'b00,2'b00,0, 0,0,1,0, 1,0,2'b11, 0,0,0,0,0, 2'b00,0);
          default:return pk(2'b00,2'b00,0, 0,0,1,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,0);
        endcase
      end
      B_WRC:   return pk(2'b01,2'b00,1, 0,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,0);
      B_ADDR:  return pk(2'b00,2'b00,0, 0,0,1,0, 0,1,2'b00, 0,0,0,0,0, 2'b00,0);
      B_LADDR: return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,0,0,1,0, 2'b00,0);
      B_MRD1:  return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b01,0);
      B_MRD2:  return pk(2'b01,2'b11,1, 0,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b01,0);
      B_GETD:  return pk(2'b01,2'b00,0, 0,1,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,0);
      B_STB:   return pk(2'b00,2'b00,0, 0,0,1,0, 1,0,2'b00, 0,0,0,0,0, 2'b00,0);
      B_MWR:   return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b10,0);
      default: return pk(2'b00,2'b00,0, 0,0,0,0, 0,0,2'b00, 0,0,0,0,0, 2'b00,1);
    endcase
  endfunction

  task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input bst_t s, input int k);
    exp_t e;
    e.tag = tag;
    e.v   = expv(s, k);
    sb.push_back(e);
  endtask

  task automatic push_fetch(input string name);
    push({name, "_if2"}, B_IF2, 0);
    push({name, "_upc"}, B_UPC, 0);
    push({name, "_dec"}, B_DEC, 0);
  endtask

  // One comparison per clock, sampled at the falling edge.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk);
      @(negedge clk);
      check(e.tag, obs_v, e.v);
    end
  endtask

  task automatic set_instr(input logic [2:0] oc, input logic [1:0] o);
    opcode = oc;
    op     = o;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_hold", obs_v, expv(B_RST, 0));

    rst_n = 1'b1;
    push("first_if1", B_IF1, 0);
    drain();

    // MOV imm: 5 cycles IF1..IF1
    set_instr(3'b110, 2'b10);
    push_fetch("movi");
    push("movi_wimm", B_WIMM, 0);
    push("movi_if1", B_IF1, 0);
    drain();

    // ADD: 8 cycles
    set_instr(3'b101, 2'b00);
    push_fetch("add");
    push("add_geta", B_GETA, 0);
    push("add_getb", B_GETB, 0);
    push("add_alu", B_ALU, K_ADD);
    push("add_wrc", B_WRC, 0);
    push("add_if1", B_IF1, 0);
    drain();

    // CMP: 7 cycles, status load only
    set_instr(3'b101, 2'b01);
    push_fetch("cmp");
    push("cmp_geta", B_GETA, 0);
    push("cmp_getb", B_GETB, 0);
    push("cmp_alu", B_ALU, K_CMP);
    push("cmp_if1", B_IF1, 0);
    drain();

    set_instr(3'b101, 2'b10);
    push_fetch("and");
    push("and_geta", B_GETA, 0);
    push("and_getb", B_GETB, 0);
    push("and_alu", B_ALU, K_AND);
    push("and_wrc", B_WRC, 0);
    push("and_if1", B_IF1, 0);
    drain();

    // MOV reg and MVN skip GETA
    set_instr(3'b110, 2'b00);
    push_fetch("movr");
    push("movr_getb", B_GETB, 0);
    push("movr_alu", B_ALU, K_MOVR);
    push("movr_wrc", B_WRC, 0);
    push("movr_if1", B_IF1, 0);
    drain();

    set_instr(3'b101, 2'b11);
    push_fetch("mvn");
    push("mvn_getb", B_GETB, 0);
    push("mvn_alu", B_ALU, K_MVN);
    push("mvn_wrc", B_WRC, 0);
    push("mvn_if1", B_IF1, 0);
    drain();

    // LDR: 9 cycles
    set_instr(3'b011, 2'b00);
    push_fetch("ldr");
    push("ldr_geta", B_GETA, 0);
    push("ldr_addr", B_ADDR, 0);
    push("ldr_laddr", B_LADDR, 0);
    push("ldr_mrd1", B_MRD1, 0);
    push("ldr_mrd2", B_MRD2, 0);
    push("ldr_if1", B_IF1, 0);
    drain();

    // Unassigned codes behave as NOP
    set_instr(3'b000, 2'b00);
    push_fetch("nop0");
    push("nop0_if1", B_IF1, 0);
    drain();

    set_instr(3'b110, 2'b01);
    push_fetch("nop1");
    push("nop1_if1", B_IF1, 0);
    drain();

    set_instr(3'b011, 2'b10);
    push_fetch("nop2");
    push("nop2_if1", B_IF1, 0);
    drain();

    // STR, aborted by reset while in MWR
    set_instr(3'b100, 2'b00);
    push_fetch("str");
    push("str_geta", B_GETA, 0);
    push("str_addr", B_ADDR, 0);
    push("str_laddr", B_LADDR, 0);
    push("str_getd", B_GETD, 0);
    push("str_stb", B_STB, 0);
    push("str_mwr", B_MWR, 0);
    drain();
    #1 rst_n = 1'b0;
    #1 check("str_abort_rst", obs_v, expv(B_RST, 0));
    @(posedge clk);
    @(negedge clk);
    check("str_abort_hold", obs_v, expv(B_RST, 0));
    rst_n = 1'b1;
    push("str_refetch_if1", B_IF1, 0);
    drain();

    // HALT sticks until reset
    set_instr(3'b111, 2'b01);
    push_fetch("halt");
    for (int i = 0; i < 22; i++) push($sformatf("halt_%0d", i), B_HALT, 0);
    drain();
    set_instr(3'b110, 2'b10);
    push("halt_ignores_instr", B_HALT, 0);
    drain();
    #1 rst_n = 1'b0;
    #1 check("halt_exit_rst", obs_v, expv(B_RST, 0));
    @(negedge clk);
    rst_n = 1'b1;
    push("halt_exit_if1", B_IF1, 0);
    drain();

    set_instr(3'b110, 2'b10);
    push_fetch("movi2");
    push("movi2_wimm", B_WIMM, 0);
    push("movi2_if1", B_IF1, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
